trigger_seq_ctrl: RTL
=====================

// Module: trigger_seq_ctrl
// PURPOSE
//  Sequences each coincidence trigger toward the Si trackers, downstream of the coincidence logic.
//  Accepts a trigger pulse and its tag, then drives a fixed-width trigger output.
//  Waits for the Si TRB busy handshake, then enforces a programmable dead time before re-arming.
//  Counts accepted, dropped and timed-out triggers for housekeeping readout.
// PARAMETERS
//  TRG_PULSE_CYC         50         trg_out high time in clk_in cycles (1us @ 50MHz)
//  BUSY_TIMEOUT_CYC      500        max cycles to wait for busy to assert after the pulse ends
//  SI_DEAD_TIME_SET_NUM  24'd15000  dead time used when dead_time_in==0 (300us)
//  TAG_W                 5          width of the trigger tag
// PORTS
//  clk_in           in   1      system clock, 50MHz
//  rst_in           in   1      synchronous reset, active-high
//  enable_in        in   1      1 = accept new triggers
//  cnt_clr_in       in   1      1-cycle pulse; clears the three housekeeping counters
//  coincid_trg_in   in   1      1-cycle trigger pulse from the coincidence logic
//  coincid_tag_in   in   TAG_W  trigger tag; valid with coincid_trg_in
//  busy_syn_in      in   2      synchronised Si TRB busy, active-high
//  busy_mask_in     in   2      1 = ignore the matching busy_syn_in bit
//  dead_time_in     in   24     dead time in cycles; 0 selects SI_DEAD_TIME_SET_NUM
//  trg_out          out  1      trigger pulse to the trackers
//  trg_tag_out      out  TAG_W  tag of the last accepted trigger
//  trg_id_out       out  16     running ID of accepted triggers; wraps at 16 bits
//  ctrl_busy_out    out  1      1 in every state except IDLE
//  state_out        out  3      current state encoding
//  acc_cnt_out      out  16     accepted-trigger count; saturates at 16'hFFFF
//  drop_cnt_out     out  16     dropped-trigger count; saturates
//  timeout_cnt_out  out  16     busy-timeout count; saturates
// BEHAVIOUR
//  Reset: all outputs are 0 and the state is IDLE (state_out=0).
//  busy_any = |(busy_syn_in & ~busy_mask_in).
//  States: IDLE=0, TRG=1, WAIT_BUSY=2, BUSY=3, DEAD=4.
//  IDLE:
//   - Accept when coincid_trg_in & enable_in & !busy_any.
//   - On accept at cycle N: trg_out=1 for cycles N+1..N+TRG_PULSE_CYC.
//   - At N+1: trg_tag_out<=coincid_tag_in, trg_id_out++, acc_cnt++. Then go to TRG.
//   - Trigger with enable_in=0: ignored, not counted.
//   - Trigger with busy_any=1 (stale busy): dropped, drop_cnt++, stay in IDLE.
//  TRG: the pulse counter expires, then go to WAIT_BUSY.
//   - If busy_mask_in==2'b11, skip WAIT_BUSY and go straight to DEAD.
//  WAIT_BUSY:
//   - busy_any=1 -> BUSY.
//   - BUSY_TIMEOUT_CYC cycles without busy -> timeout_cnt++, go to DEAD.
//  BUSY: busy_any=0 -> DEAD.
//  DEAD: count the effective dead time D cycles, then go to IDLE. Triggers can be accepted again on the next cycle.
//  Any coincid_trg_in outside IDLE: drop_cnt++; no effect on the sequence.
//  Mask and dead-time inputs are sampled every cycle; a dead_time_in change takes effect at the next DEAD entry.
//  enable_in falling mid-sequence: the current sequence completes normally.
//  cnt_clr_in and an increment in the same cycle: clear wins, counter=0.
//  trg_id_out is never cleared by cnt_clr_in; only rst_in clears it.
//  rst_in mid-sequence: trg_out drops on the next edge, state returns to IDLE, all counters=0.
//  Counters use 16-bit unsigned arithmetic. The dead-time counter is 24-bit and counts up to D-1.
// STRUCTURE
//  Package trg_seq_pkg holds:
//   - state enum trg_state_t (3 bits, values above)
//   - localparams CNT_W=16 and DT_W=24
//  Sub-module sat_cnt16 (inc, clr, q; clear has priority) is instantiated 3x for the counters.
//  The FSM plus one shared phase timer (pulse, timeout and dead time reuse it) stays in the top.
// TESTING (bench params: TRG_PULSE_CYC=4, BUSY_TIMEOUT_CYC=8, dead_time_in=10)
//  1. Trigger at N with tag 5'h13; busy rises at N+7, falls at N+20.
//     -> trg_out high N+1..N+4, trg_tag_out=5'h13, trg_id_out=1.
//     -> state sequence IDLE,TRG,WAIT_BUSY,BUSY,DEAD,IDLE; back in IDLE at N+31; acc_cnt=1.
//  2. No busy after the pulse.
//     -> timeout_cnt=1 after 8 cycles in WAIT_BUSY; DEAD for 10 cycles; IDLE again.
//  3. 3 triggers during BUSY/DEAD plus 1 in IDLE with busy_any=1.
//     -> drop_cnt=4, acc_cnt unchanged, no extra trg_out pulse.
//  4. busy_mask_in=2'b11 with busy toggling -> TRG goes straight to DEAD; timeout_cnt stays 0.
//  5. acc_cnt preloaded to 16'hFFFF: a further trigger leaves it at 16'hFFFF.
//     -> cnt_clr_in in the same cycle as an accept leaves it at 0.
//  6. rst_in asserted in the middle of the trg_out pulse.
//     -> next cycle: trg_out=0, state_out=0, all counters 0, trg_id_out=0.

Source files
------------

// File: rtl/trg_seq_pkg.sv
// Shared types and widths for the trigger sequencer.
package trg_seq_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DT_W  = 24;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRG       = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_BUSY      = 3'd3,
        ST_DEAD      = 3'd4
    } trg_state_t;

endpackage

// File: rtl/sat_cnt16.sv
// Saturating housekeeping counter; a clear in the same cycle as an increment wins.
module sat_cnt16
    import trg_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/trigger_seq_ctrl.sv
// Sequences a coincidence trigger to the Si trackers: pulse, busy handshake, dead time,
// with housekeeping counters for accepted, dropped and timed-out triggers.
module trigger_seq_ctrl
    import trg_seq_pkg::*;
#(
    parameter int unsigned     TRG_PULSE_CYC        = 50,
    parameter int unsigned     BUSY_TIMEOUT_CYC     = 500,
    parameter logic [DT_W-1:0] SI_DEAD_TIME_SET_NUM = 24'd15000,
    parameter int unsigned     TAG_W                = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enable_in,
    input  logic             cnt_clr_in,
    input  logic             coincid_trg_in,
    input  logic [TAG_W-1:0] coincid_tag_in,
    input  logic [1:0]       busy_syn_in,
    input  logic [1:0]       busy_mask_in,
    input  logic [DT_W-1:0]  dead_time_in,
    output logic             trg_out,
    output logic [TAG_W-1:0] trg_tag_out,
    output logic [CNT_W-1:0] trg_id_out,
    output logic             ctrl_busy_out,
    output logic [2:0]       state_out,
    output logic [CNT_W-1:0] acc_cnt_out,
    output logic [CNT_W-1:0] drop_cnt_out,
    output logic [CNT_W-1:0] timeout_cnt_out
);

    localparam logic [DT_W-1:0] PULSE_LAST   = DT_W'(TRG_PULSE_CYC - 1);
    localparam logic [DT_W-1:0] TIMEOUT_LAST = DT_W'(BUSY_TIMEOUT_CYC - 1);

    trg_state_t       state_q, state_d;
    logic [DT_W-1:0]  tmr_q, tmr_d;
    logic [DT_W-1:0]  dt_q, dt_d;
    logic             trg_q, trg_d;
    logic             ctrl_busy_q, ctrl_busy_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] id_q, id_d;

    logic             busy_any;
    logic [DT_W-1:0]  eff_dt;
    logic             acc_inc, drop_inc, to_inc;

    assign busy_any = |(busy_syn_in & ~busy_mask_in);
    assign eff_dt   = (dead_time_in == '0) ? SI_DEAD_TIME_SET_NUM : dead_time_in;

    // Next state, shared phase timer and trigger bookkeeping.
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        id_d     = id_q;
        dt_d     = dt_q;
        acc_inc  = 1'b0;
        drop_inc = 1'b0;
        to_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coincid_trg_in && enable_in) begin
                    if (busy_any) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = ST_TRG;
                        tag_d   = coincid_tag_in;
                        id_d    = id_q + CNT_W'(1);
                        acc_inc = 1'b1;
                    end
                end
            end
            ST_TRG: begin
                if (tmr_q == PULSE_LAST) begin
                    state_d = (busy_mask_in == 2'b11) ? ST_DEAD : ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (busy_any) begin
                    state_d = ST_BUSY;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    state_d = ST_DEAD;
                    to_inc  = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!busy_any) begin
                    state_d = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (tmr_q == dt_q - DT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && coincid_trg_in) begin
            drop_inc = 1'b1;
        end

        // Dead time is latched on entry so a mid-DEAD change waits for the next sequence.
        if ((state_d == ST_DEAD) && (state_q != ST_DEAD)) begin
            dt_d = eff_dt;
        end

        if ((state_d != state_q) || (state_d == ST_IDLE)) begin
            tmr_d = '0;
        end else begin
            tmr_d = tmr_q + DT_W'(1);
        end

        trg_d       = (state_d == ST_TRG);
        ctrl_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            dt_q        <= '0;
            trg_q       <= 1'b0;
            ctrl_busy_q <= 1'b0;
            tag_q       <= '0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            dt_q        <= dt_d;
            trg_q       <= trg_d;
            ctrl_busy_q <= ctrl_busy_d;
            tag_q       <= tag_d;
            id_q        <= id_d;
        end
    end

    sat_cnt16 u_acc_cnt (
        .clk (clk_in),
        .rst (rst_in),
        .inc (acc_inc),
        .clr (cnt_clr_in),
        .q   (acc_cnt_out)
    );

    sat_cnt16 u_drop_cnt (
        .clk (clk_in),
        .rst (rst_in),
        .inc (drop_inc),
        .clr (cnt_clr_in),
        .q   (drop_cnt_out)
    );

    sat_cnt16 u_timeout_cnt (
        .clk (clk_in),
        .rst (rst_in),
        .inc (to_inc),
        .clr (cnt_clr_in),
        .q   (timeout_cnt_out)
    );

    assign trg_out       = trg_q;
    assign trg_tag_out   = tag_q;
    assign trg_id_out    = id_q;
    assign ctrl_busy_out = ctrl_busy_q;
    assign state_out     = state_q;

endmodule
